// File: rtl/evr_pkg.sv
// evr_pkg: shared sequencer state encoding and status word field offsets.
package evr_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PULSE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_WAIT_SYNC = 3'd3,
    S_LOCKED    = 3'd4,
    S_FAILED    = 3'd5
  } evr_state_t;
  localparam int ST_STATE_LSB    = 0;
  localparam int ST_LOCKED_BIT   = 3;
  localparam int ST_FAILED_BIT   = 4;
  localparam int ST_CPLL_BIT     = 5;
  localparam int ST_ATTEMPTS_LSB = 8;
  localparam int ST_RELOCK_LSB   = 16;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/evr_bit_sync.sv
// evr_bit_sync: 2-flop synchronizer with asynchronous active-low reset.
module evr_bit_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end
  assign q = sync;
endmodule

// File: rtl/evr_rx_align_sequencer.sv
// evr_rx_align_sequencer: pulses GTY reset_all until the receiver synchronises,
// retries up to MAX_ATTEMPTS times and relocks on loss of sync.
module evr_rx_align_sequencer
  import evr_pkg::*;
#(
  parameter int RESET_PULSE_CYCLES  = 64,
  parameter int DONE_TIMEOUT_CYCLES = 2**20,
  parameter int SYNC_TIMEOUT_CYCLES = 2**16,
  parameter int MAX_ATTEMPTS        = 200
) (
  input  logic        sysClk,
  input  logic        sysReset_n,
  input  logic        enable,
  input  logic        restart,
  input  logic        autoRelock,
  input  logic        rxSynchronized,
  input  logic        rxResetDone,
  input  logic        cplllocked,
  output logic        resetAll,
  output logic        locked,
  output logic        failed,
  output logic [7:0]  attempts,
  output logic [15:0] relockCount,
  output logic [31:0] status
);
  localparam int TW = $clog2(max3(RESET_PULSE_CYCLES, DONE_TIMEOUT_CYCLES, SYNC_TIMEOUT_CYCLES)) + 1;
  localparam logic [TW-1:0] PULSE_LOAD = TW'(RESET_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] DONE_LOAD  = TW'(DONE_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] SYNC_LOAD  = TW'(SYNC_TIMEOUT_CYCLES - 1);
  evr_state_t      state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [7:0]      att_n;
  logic [15:0]     rc_n;
  logic            rx_sync_s, done_s, cpllSync, sync_q, fall, retry;
  evr_bit_sync u_sync_rx   (.clk(sysClk), .rst_n(sysReset_n), .d(rxSynchronized), .q(rx_sync_s));
  evr_bit_sync u_sync_done (.clk(sysClk), .rst_n(sysReset_n), .d(rxResetDone),    .q(done_s));
  evr_bit_sync u_sync_cpll (.clk(sysClk), .rst_n(sysReset_n), .d(cplllocked),     .q(cpllSync));
  assign fall = sync_q & ~rx_sync_s;
  always_comb begin
    state_n = state;
    timer_n = timer;
    att_n   = attempts;
    retry   = 1'b0;
    rc_n    = (state == S_LOCKED && fall && ~&relockCount) ? relockCount + 16'd1 : relockCount;
    if (!enable) begin
      state_n = S_IDLE;
    end else if (restart) begin
      state_n = S_PULSE;
      timer_n = PULSE_LOAD;
      att_n   = 8'd1;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_PULSE;
          timer_n = PULSE_LOAD;
          att_n   = 8'd1;
        end
        S_PULSE: begin
          state_n = (timer == '0) ? S_WAIT_DONE : S_PULSE;
          timer_n = (timer == '0) ? DONE_LOAD : timer - TW'(1);
        end
        S_WAIT_DONE: begin
          state_n = done_s ? S_WAIT_SYNC : S_WAIT_DONE;
          timer_n = done_s ? SYNC_LOAD : timer - TW'(1);
          retry   = !done_s && timer == '0;
        end
        S_WAIT_SYNC: begin
          state_n = rx_sync_s ? S_LOCKED : S_WAIT_SYNC;
          timer_n = timer - TW'(1);
          retry   = !rx_sync_s && timer == '0;
        end
        S_LOCKED: begin
          if (fall && autoRelock) begin
            state_n = S_PULSE;
            timer_n = PULSE_LOAD;
            att_n   = 8'd1;
          end
        end
        S_FAILED: state_n = S_FAILED;
        default:  state_n = S_IDLE;
      endcase
      // Timeouts either start another attempt or give up once the budget is spent
      if (retry) begin
        state_n = (attempts < 8'(MAX_ATTEMPTS)) ? S_PULSE : S_FAILED;
        timer_n = PULSE_LOAD;
        att_n   = (attempts < 8'(MAX_ATTEMPTS)) ? attempts + 8'd1 : attempts;
      end
    end
  end
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      attempts    <= '0;
      relockCount <= '0;
      sync_q      <= 1'b0;
      resetAll    <= 1'b0;
      locked      <= 1'b0;
      failed      <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      attempts    <= att_n;
      relockCount <= rc_n;
      sync_q      <= rx_sync_s;
      resetAll    <= state_n == S_PULSE;
      locked      <= state_n == S_LOCKED;
      failed      <= state_n == S_FAILED;
    end
  end
  always_comb begin
    status = '0;
    status[ST_STATE_LSB +: 3]     = state;
    status[ST_LOCKED_BIT]         = locked;
    status[ST_FAILED_BIT]         = failed;
    status[ST_CPLL_BIT]           = cpllSync;
    status[ST_ATTEMPTS_LSB +: 8]  = attempts;
    status[ST_RELOCK_LSB +: 16]   = relockCount;
  end
endmodule

// File: tb/tb_evr_rx_align_sequencer.sv
// tb_evr_rx_align_sequencer: scenario tasks plus a pulse scoreboard that checks
// every resetAll pulse against expectations queued by the scenarios.
module tb_evr_rx_align_sequencer;
  logic        sysClk = 1'b0;
  logic        sysReset_n = 1'b0;
  logic        enable = 1'b0, restart = 1'b0, autoRelock = 1'b0;
  logic        rxSynchronized = 1'b0, rxResetDone = 1'b0, cplllocked = 1'b0;
  logic        resetAll, locked, failed;
  logic [7:0]  attempts;
  logic [15:0] relockCount;
  logic [31:0] status;
  int errors = 0;
  int checks = 0;
  typedef struct {int len; int gap; int ws;} pulse_t;
  pulse_t exp_q[$];
  int hi_cnt = 0, lo_cnt = 0, ws_cnt = 0, gap_l = 0, ws_l = 0, rises = 0;
  logic prev = 1'b0;

  evr_rx_align_sequencer #(
    .RESET_PULSE_CYCLES(4), .DONE_TIMEOUT_CYCLES(20), .SYNC_TIMEOUT_CYCLES(30), .MAX_ATTEMPTS(3)
  ) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .enable(enable), .restart(restart),
    .autoRelock(autoRelock), .rxSynchronized(rxSynchronized), .rxResetDone(rxResetDone),
    .cplllocked(cplllocked), .resetAll(resetAll), .locked(locked), .failed(failed),
    .attempts(attempts), .relockCount(relockCount), .status(status)
  );

  always #5 sysClk = ~sysClk;

  // Pulse monitor: measures each resetAll pulse and compares it with the next expectation
  always @(posedge sysClk) begin
    #1;
    if (!sysReset_n) begin
      hi_cnt = 0; lo_cnt = 0; ws_cnt = 0; gap_l = 0; ws_l = 0; rises = 0; prev = 1'b0;
    end else begin
      if (resetAll && !prev) begin
        gap_l = lo_cnt; ws_l = ws_cnt; hi_cnt = 0; rises++;
      end
      if (!resetAll && prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_pulse: got pulse len=%0d gap=%0d, expected no pulse", hi_cnt, gap_l);
        end else begin
          pulse_t e;
          e = exp_q.pop_front();
          if (hi_cnt != e.len || (e.gap >= 0 && gap_l != e.gap) || (e.ws >= 0 && ws_l != e.ws)) begin
            errors++;
            $display("FAIL sb_pulse: got len=%0d gap=%0d ws=%0d, expected len=%0d gap=%0d ws=%0d",
                     hi_cnt, gap_l, ws_l, e.len, e.gap, e.ws);
          end
        end
        lo_cnt = 0; ws_cnt = 0;
      end
      if (resetAll) hi_cnt++;
      else begin
        lo_cnt++;
        if (status[2:0] == 3'd3) ws_cnt++;
      end
      prev = resetAll;
    end
  end

  task automatic expect_pulse(input int len, input int gap, input int ws);
    pulse_t p;
    p.len = len; p.gap = gap; p.ws = ws;
    exp_q.push_back(p);
  endtask

  task automatic do_reset();
    sysReset_n = 1'b0; enable = 1'b0; restart = 1'b0; autoRelock = 1'b0;
    rxSynchronized = 1'b0; rxResetDone = 1'b0; cplllocked = 1'b0;
    repeat (3) @(negedge sysClk);
    exp_q.delete();
    sysReset_n = 1'b1;
    @(negedge sysClk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (resetAll !== 1'b0) begin errors++; $display("FAIL reset_resetAll: got %b, expected 0", resetAll); end
    checks++; if (locked !== 1'b0 || failed !== 1'b0) begin errors++; $display("FAIL reset_flags: got locked=%b failed=%b, expected 0 0", locked, failed); end
    checks++; if (attempts !== 8'd0 || relockCount !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d %0d, expected 0 0", attempts, relockCount); end
    checks++; if (status !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, expected 00000000", status); end
    cplllocked = 1'b1;
    @(negedge sysClk);
    checks++; if (status[5] !== 1'b0) begin errors++; $display("FAIL cpll_sync_early: got %b, expected 0", status[5]); end
    @(negedge sysClk);
    checks++; if (status !== 32'h20) begin errors++; $display("FAIL cpll_sync: got status %h, expected 00000020", status); end
  endtask

  task automatic test_happy();
    int n;
    do_reset();
    expect_pulse(4, -1, -1);
    enable = 1'b1;
    for (int i = 0; i < 20 && !resetAll; i++) @(negedge sysClk);
    for (int i = 0; i < 20 && resetAll; i++) @(negedge sysClk);
    checks++; if (resetAll !== 1'b0) begin errors++; $display("FAIL happy_pulse_end: got %b, expected 0", resetAll); end
    repeat (5) @(negedge sysClk);
    rxResetDone = 1'b1;
    repeat (10) @(negedge sysClk);
    rxSynchronized = 1'b1;
    n = 0;
    while (!locked && n < 50) begin @(negedge sysClk); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL happy_lock_latency: got %0d cycles, expected 3", n); end
    repeat (40) @(negedge sysClk);
    checks++; if (attempts !== 8'd1) begin errors++; $display("FAIL happy_attempts: got %0d, expected 1", attempts); end
    checks++; if (status[4:0] !== 5'b01100) begin errors++; $display("FAIL happy_status: got %b, expected 01100", status[4:0]); end
    checks++; if (exp_q.size() != 0 || rises != 1) begin errors++; $display("FAIL happy_pulses: got %0d pulses, %0d pending, expected 1 and 0", rises, exp_q.size()); end
  endtask

  task automatic test_retry_lock();
    do_reset();
    rxResetDone = 1'b1;
    repeat (3) @(negedge sysClk);
    expect_pulse(4, -1, -1); expect_pulse(4, -1, 30); expect_pulse(4, -1, 30);
    enable = 1'b1;
    for (int i = 0; i < 200 && attempts != 8'd3; i++) @(negedge sysClk);
    rxSynchronized = 1'b1;
    for (int i = 0; i < 100 && !locked; i++) @(negedge sysClk);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL retry_locked: got %b, expected 1", locked); end
    repeat (20) @(negedge sysClk);
    checks++; if (attempts !== 8'd3) begin errors++; $display("FAIL retry_attempts: got %0d, expected 3", attempts); end
    checks++; if (exp_q.size() != 0 || rises != 3) begin errors++; $display("FAIL retry_pulses: got %0d pulses, %0d pending, expected 3 and 0", rises, exp_q.size()); end
  endtask

  task automatic test_exhaustion();
    int r0;
    bit stray;
    do_reset();
    rxResetDone = 1'b1;
    repeat (3) @(negedge sysClk);
    expect_pulse(4, -1, -1); expect_pulse(4, -1, 30); expect_pulse(4, -1, 30);
    enable = 1'b1;
    for (int i = 0; i < 400 && !failed; i++) @(negedge sysClk);
    checks++; if (failed !== 1'b1 || status[2:0] !== 3'd5) begin errors++; $display("FAIL exhaust_failed: got failed=%b state=%0d, expected 1 5", failed, status[2:0]); end
    checks++; if (attempts !== 8'd3) begin errors++; $display("FAIL exhaust_attempts: got %0d, expected 3", attempts); end
    r0 = rises; stray = 1'b0;
    for (int i = 0; i < 100; i++) begin @(negedge sysClk); if (resetAll) stray = 1'b1; end
    checks++; if (stray || rises != r0 || exp_q.size() != 0) begin errors++; $display("FAIL exhaust_quiet: got stray=%b pulses=%0d pending=%0d, expected 0 %0d 0", stray, rises, exp_q.size(), r0); end
    expect_pulse(4, -1, -1);
    restart = 1'b1;
    @(negedge sysClk);
    restart = 1'b0;
    checks++; if (status[2:0] !== 3'd1 || resetAll !== 1'b1 || failed !== 1'b0) begin errors++; $display("FAIL exhaust_restart_state: got state=%0d resetAll=%b failed=%b, expected 1 1 0", status[2:0], resetAll, failed); end
    checks++; if (attempts !== 8'd1) begin errors++; $display("FAIL exhaust_restart_attempts: got %0d, expected 1", attempts); end
    repeat (10) @(negedge sysClk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL exhaust_restart_pulse: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_done_timeout();
    do_reset();
    expect_pulse(4, -1, -1); expect_pulse(4, 20, 0); expect_pulse(4, 20, 0);
    enable = 1'b1;
    for (int i = 0; i < 300 && !failed; i++) @(negedge sysClk);
    checks++; if (failed !== 1'b1) begin errors++; $display("FAIL done_to_failed: got %b, expected 1", failed); end
    checks++; if (exp_q.size() != 0 || rises != 3) begin errors++; $display("FAIL done_to_pulses: got %0d pulses, %0d pending, expected 3 and 0", rises, exp_q.size()); end
  endtask

  task automatic test_relock_auto();
    do_reset();
    rxResetDone = 1'b1; rxSynchronized = 1'b1; autoRelock = 1'b1;
    repeat (3) @(negedge sysClk);
    expect_pulse(4, -1, -1);
    enable = 1'b1;
    for (int i = 0; i < 100 && !locked; i++) @(negedge sysClk);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_auto_lock: got %b, expected 1", locked); end
    expect_pulse(4, -1, -1);
    rxSynchronized = 1'b0;
    for (int i = 0; i < 20 && !resetAll; i++) @(negedge sysClk);
    checks++; if (resetAll !== 1'b1 || status[2:0] !== 3'd1) begin errors++; $display("FAIL relock_auto_pulse: got resetAll=%b state=%0d, expected 1 1", resetAll, status[2:0]); end
    checks++; if (relockCount !== 16'd1 || attempts !== 8'd1) begin errors++; $display("FAIL relock_auto_counts: got relock=%0d attempts=%0d, expected 1 1", relockCount, attempts); end
    rxSynchronized = 1'b1;
    for (int i = 0; i < 100 && !locked; i++) @(negedge sysClk);
    checks++; if (locked !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL relock_auto_relocked: got locked=%b pending=%0d, expected 1 0", locked, exp_q.size()); end
  endtask

  task automatic test_relock_hold();
    int r0;
    do_reset();
    rxResetDone = 1'b1; rxSynchronized = 1'b1;
    repeat (3) @(negedge sysClk);
    expect_pulse(4, -1, -1);
    enable = 1'b1;
    for (int i = 0; i < 100 && !locked; i++) @(negedge sysClk);
    r0 = rises;
    rxSynchronized = 1'b0;
    repeat (20) @(negedge sysClk);
    checks++; if (relockCount !== 16'd1 || status[31:16] !== 16'd1) begin errors++; $display("FAIL relock_hold_count: got %0d, expected 1", relockCount); end
    checks++; if (locked !== 1'b1 || status[2:0] !== 3'd4) begin errors++; $display("FAIL relock_hold_state: got locked=%b state=%0d, expected 1 4", locked, status[2:0]); end
    checks++; if (rises != r0 || resetAll !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL relock_hold_nopulse: got pulses=%0d resetAll=%b, expected %0d 0", rises, resetAll, r0); end
  endtask

  task automatic test_priority();
    do_reset();
    expect_pulse(1, -1, -1);
    enable = 1'b1;
    for (int i = 0; i < 20 && !resetAll; i++) @(negedge sysClk);
    enable = 1'b0; restart = 1'b1;
    @(negedge sysClk);
    restart = 1'b0;
    checks++; if (resetAll !== 1'b0 || status[2:0] !== 3'd0) begin errors++; $display("FAIL prio_idle: got resetAll=%b state=%0d, expected 0 0", resetAll, status[2:0]); end
    repeat (5) @(negedge sysClk);
    checks++; if (exp_q.size() != 0 || status[2:0] !== 3'd0) begin errors++; $display("FAIL prio_stay_idle: got pending=%0d state=%0d, expected 0 0", exp_q.size(), status[2:0]); end
  endtask

  task automatic test_restart_in_pulse();
    do_reset();
    expect_pulse(5, -1, -1);
    enable = 1'b1;
    for (int i = 0; i < 20 && !resetAll; i++) @(negedge sysClk);
    restart = 1'b1;
    @(negedge sysClk);
    restart = 1'b0;
    checks++; if (attempts !== 8'd1 || status[2:0] !== 3'd1) begin errors++; $display("FAIL restart_pulse_state: got attempts=%0d state=%0d, expected 1 1", attempts, status[2:0]); end
    repeat (10) @(negedge sysClk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_pulse_len: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 20 && !resetAll; i++) @(negedge sysClk);
    @(negedge sysClk);
    sysReset_n = 1'b0;
    #1;
    checks++; if (resetAll !== 1'b0 || locked !== 1'b0 || failed !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got %b%b%b, expected 000", resetAll, locked, failed); end
    checks++; if (attempts !== 8'd0 || relockCount !== 16'd0 || status !== 32'h0) begin errors++; $display("FAIL midrst_counters: got attempts=%0d status=%h, expected 0 00000000", attempts, status); end
    repeat (2) @(negedge sysClk);
    expect_pulse(4, -1, -1);
    sysReset_n = 1'b1;
    #1;
    checks++; if (status[2:0] !== 3'd0) begin errors++; $display("FAIL midrst_idle: got state=%0d, expected 0", status[2:0]); end
    @(negedge sysClk);
    checks++; if (status[2:0] !== 3'd1 || attempts !== 8'd1) begin errors++; $display("FAIL midrst_restart: got state=%0d attempts=%0d, expected 1 1", status[2:0], attempts); end
    repeat (10) @(negedge sysClk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_pulse: got %0d pending, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_retry_lock();
    test_exhaustion();
    test_done_timeout();
    test_relock_auto();
    test_relock_hold();
    test_priority();
    test_restart_in_pulse();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
